// File: rtl/odd_counter_pkg.sv
// Shared constants and helpers for odd_bounce_counter.
// Optional scan chain is enabled with ODD_BOUNCE_COUNTER_SCAN_EN.
package odd_counter_pkg;

  localparam int MODE_BOUNCE = 0;
  localparam int MODE_WRAP   = 1;

  function automatic int cnt_min(input int width, input int parity);
    return (parity != 0) ? 1 : 0;
  endfunction

  function automatic int cnt_max(input int width, input int parity);
    return (1 << width) - ((parity != 0) ? 1 : 2);
  endfunction

  // Scan chain covers {dir, count, turn, wrap}.
  function automatic int scan_len(input int width);
    return width + 3;
  endfunction

endpackage

// File: rtl/odd_bounce_counter_scan_dff.sv
// Async-reset-low state flop; gains a scan mux when ODD_BOUNCE_COUNTER_SCAN_EN is defined.
module scan_dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
  input  logic scan_en_i,
  input  logic scan_in_i,
`endif
  output logic q_o
);

  logic d_mux;
  logic q_q;

`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
  assign d_mux = scan_en_i ? scan_in_i : d_i;
`else
  assign d_mux = d_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= d_mux;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/odd_bounce_counter.sv
// Step-by-2 bounce/wrap counter over the odd or even values of a WIDTH-bit range.
// Define ODD_BOUNCE_COUNTER_SCAN_EN to add a scan chain over {dir, count, turn, wrap}.
module odd_bounce_counter
  import odd_counter_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int PARITY = 1,
  parameter int MODE   = MODE_BOUNCE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir_in,
`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
`endif
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             turn,
  output logic             wrap
);

  localparam int                    SCAN_LEN = scan_len(WIDTH);
  localparam logic [WIDTH-1:0]      MIN_C    = WIDTH'(cnt_min(WIDTH, PARITY));
  localparam logic [WIDTH-1:0]      MAX_C    = WIDTH'(cnt_max(WIDTH, PARITY));
  localparam logic [SCAN_LEN-1:0]   RST_VEC  = {1'b1, MIN_C, 2'b00};

  logic [WIDTH-1:0]    count_q, count_d;
  logic                dir_q, dir_d;
  logic                turn_q, turn_d;
  logic                wrap_q, wrap_d;
  logic [SCAN_LEN-1:0] state_q, state_d;
  logic [WIDTH:0]      up_sum, dn_diff;
  logic [WIDTH-1:0]    load_cnt;
  logic                unused_ok;

  // The extra top bit of the sums is the carry/borrow that flags a wrap.
  assign up_sum    = {1'b0, count_q} + (WIDTH+1)'(2);
  assign dn_diff   = {1'b0, count_q} - (WIDTH+1)'(2);
  assign load_cnt  = {load_val[WIDTH-1:1], 1'(PARITY)};
  assign unused_ok = ^{load_val[0], dir_in};

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    turn_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_cnt;
      if (MODE == MODE_WRAP) begin
        dir_d = dir_in;
      end else if (load_cnt == MAX_C) begin
        dir_d = 1'b0;
      end else if (load_cnt == MIN_C) begin
        dir_d = 1'b1;
      end
    end else if (en) begin
      if (MODE == MODE_WRAP) begin
        dir_d = dir_in;
        if (dir_in) begin
          count_d = up_sum[WIDTH-1:0];
          wrap_d  = up_sum[WIDTH];
        end else begin
          count_d = dn_diff[WIDTH-1:0];
          wrap_d  = dn_diff[WIDTH];
        end
      end else if (dir_q) begin
        if (count_q >= MAX_C) begin
          // Already at the far end (only reachable via scan): reverse silently.
          dir_d   = 1'b0;
          count_d = dn_diff[WIDTH-1:0];
        end else begin
          count_d = up_sum[WIDTH-1:0];
          if (up_sum[WIDTH-1:0] == MAX_C) begin
            dir_d  = 1'b0;
            turn_d = 1'b1;
          end
        end
      end else begin
        if (count_q <= MIN_C) begin
          dir_d   = 1'b1;
          count_d = up_sum[WIDTH-1:0];
        end else begin
          count_d = dn_diff[WIDTH-1:0];
          if (dn_diff[WIDTH-1:0] == MIN_C) begin
            dir_d  = 1'b1;
            turn_d = 1'b1;
          end
        end
      end
    end
  end

  assign state_d = {dir_d, count_d, turn_d, wrap_d};
  assign {dir_q, count_q, turn_q, wrap_q} = state_q;

`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
  logic [SCAN_LEN-1:0] chain_in;
  assign chain_in = {scan_in, state_q[SCAN_LEN-1:1]};
  assign scan_out = state_q[0];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < SCAN_LEN; gi++) begin : g_state
      scan_dff #(.RST_VAL(RST_VEC[gi])) u_ff (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_i       (state_d[gi]),
`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
        .scan_en_i (scan_en),
        .scan_in_i (chain_in[gi]),
`endif
        .q_o       (state_q[gi])
      );
    end
  endgenerate

  assign count = count_q;
  assign dir   = dir_q;
  assign turn  = turn_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_odd_bounce_counter.sv
// Directed bench for odd_bounce_counter: four configurations share one clock.
// Scan checks are compiled in only when ODD_BOUNCE_COUNTER_SCAN_EN is defined.
module tb_odd_bounce_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // A: WIDTH=3 odd bounce
  logic a_en = 0, a_load = 0, a_dir_in = 0;
  logic [2:0] a_load_val = '0, a_count;
  logic a_dir, a_turn, a_wrap;
  // B: WIDTH=4 odd bounce
  logic b_en = 0, b_load = 0, b_dir_in = 0;
  logic [3:0] b_load_val = '0, b_count;
  logic b_dir, b_turn, b_wrap;
  // C: WIDTH=3 odd wrap
  logic c_en = 0, c_load = 0, c_dir_in = 0;
  logic [2:0] c_load_val = '0, c_count;
  logic c_dir, c_turn, c_wrap;
  // D: WIDTH=3 even bounce
  logic d_en = 0, d_load = 0, d_dir_in = 0;
  logic [2:0] d_load_val = '0, d_count;
  logic d_dir, d_turn, d_wrap;

`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
  logic a_scan_en = 0, a_scan_in = 0, a_scan_out;
  logic o_scan_en = 0, o_scan_in = 0;
  logic b_scan_out, c_scan_out, d_scan_out;
`endif

  odd_bounce_counter #(.WIDTH(3), .PARITY(1), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .load(a_load), .load_val(a_load_val), .dir_in(a_dir_in),
`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
    .scan_en(a_scan_en), .scan_in(a_scan_in), .scan_out(a_scan_out),
`endif
    .count(a_count), .dir(a_dir), .turn(a_turn), .wrap(a_wrap));

  odd_bounce_counter #(.WIDTH(4), .PARITY(1), .MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .load(b_load), .load_val(b_load_val), .dir_in(b_dir_in),
`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
    .scan_en(o_scan_en), .scan_in(o_scan_in), .scan_out(b_scan_out),
`endif
    .count(b_count), .dir(b_dir), .turn(b_turn), .wrap(b_wrap));

  odd_bounce_counter #(.WIDTH(3), .PARITY(1), .MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .load(c_load), .load_val(c_load_val), .dir_in(c_dir_in),
`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
    .scan_en(o_scan_en), .scan_in(o_scan_in), .scan_out(c_scan_out),
`endif
    .count(c_count), .dir(c_dir), .turn(c_turn), .wrap(c_wrap));

  odd_bounce_counter #(.WIDTH(3), .PARITY(0), .MODE(0)) u_d (
    .clk(clk), .rst_n(rst_n), .en(d_en), .load(d_load), .load_val(d_load_val), .dir_in(d_dir_in),
`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
    .scan_en(o_scan_en), .scan_in(o_scan_in), .scan_out(d_scan_out),
`endif
    .count(d_count), .dir(d_dir), .turn(d_turn), .wrap(d_wrap));

  typedef struct {
    logic       en;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] exp_count;
    logic       exp_dir;
    logic       exp_turn;
    logic       exp_wrap;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {en, load, load_val, count, dir, turn, wrap} after each edge, from reset (1, up)
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'd6, 3'd7, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0};

    #12;
    check("reset_count", int'(a_count), 1);
    check("reset_dir", int'(a_dir), 1);
    check("reset_turn", int'(a_turn), 0);
    check("reset_wrap", int'(a_wrap), 0);
    check("reset_even_count", int'(d_count), 0);
    rst_n = 1'b1;
    #10;

    for (int i = 0; i < NVEC; i++) begin
      a_en = vecs[i].en;
      a_load = vecs[i].load;
      a_load_val = vecs[i].load_val;
      tick();
      $display("vec %0d: en=%0b load=%0b lv=%0d -> count=%0d dir=%0b turn=%0b wrap=%0b",
               i, vecs[i].en, vecs[i].load, vecs[i].load_val, a_count, a_dir, a_turn, a_wrap);
      check($sformatf("vec%0d_count", i), int'(a_count), int'(vecs[i].exp_count));
      check($sformatf("vec%0d_dir", i), int'(a_dir), int'(vecs[i].exp_dir));
      check($sformatf("vec%0d_turn", i), int'(a_turn), int'(vecs[i].exp_turn));
      check($sformatf("vec%0d_wrap", i), int'(a_wrap), int'(vecs[i].exp_wrap));
    end
    a_en = 0;
    a_load = 0;
    // A now holds count=3, dir=0; step once more to reach 1 then 3 -- instead reset mid-cycle at 5
    a_load = 1; a_load_val = 3'd4;
    tick();
    a_load = 0;
    check("pre_reset_count", int'(a_count), 5);
    check("pre_reset_dir", int'(a_dir), 0);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-cycle -> count=%0d dir=%0b", a_count, a_dir);
    check("async_reset_count", int'(a_count), 1);
    check("async_reset_dir", int'(a_dir), 1);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("hold %0d -> count=%0d turn=%0b", i, a_count, a_turn);
      check("hold_count", int'(a_count), 1);
      check("hold_turn", int'(a_turn), 0);
    end

`ifdef ODD_BOUNCE_COUNTER_SCAN_EN
    begin
      // Target contents {dir,c2,c1,c0,turn,wrap} = 1,0,1,1,0,0; wrap bit enters first.
      logic [5:0] pat;
      pat = 6'b101100;
      a_scan_en = 1;
      for (int i = 0; i < 6; i++) begin
        a_scan_in = pat[i];
        tick();
        $display("scan shift %0d in=%0b -> scan_out=%0b", i, pat[i], a_scan_out);
      end
      a_scan_en = 0;
      check("scan_dir", int'(a_dir), 1);
      check("scan_count", int'(a_count), 3);
      check("scan_turn", int'(a_turn), 0);
      check("scan_wrap", int'(a_wrap), 0);
      check("scan_out", int'(a_scan_out), 0);
      a_en = 1;
      tick();
      a_en = 0;
      $display("post-scan step -> count=%0d", a_count);
      check("scan_step_count", int'(a_count), 5);
    end
`endif

    // B: WIDTH=4 load with parity forcing, then MAX load and step down
    b_load = 1; b_en = 1; b_load_val = 4'b0110;
    tick();
    $display("B load 6 -> count=%0d dir=%0b turn=%0b", b_count, b_dir, b_turn);
    check("b_load6_count", int'(b_count), 7);
    check("b_load6_dir", int'(b_dir), 1);
    check("b_load6_turn", int'(b_turn), 0);
    b_load_val = 4'd15;
    tick();
    b_load = 0;
    $display("B load 15 -> count=%0d dir=%0b", b_count, b_dir);
    check("b_load15_count", int'(b_count), 15);
    check("b_load15_dir", int'(b_dir), 0);
    tick();
    b_en = 0;
    $display("B step -> count=%0d dir=%0b", b_count, b_dir);
    check("b_step_count", int'(b_count), 13);

    // C: wrap mode up through MAX, then down through MIN
    c_load = 1; c_load_val = 3'd7; c_dir_in = 1;
    tick();
    c_load = 0;
    check("c_load_count", int'(c_count), 7);
    c_en = 1; c_dir_in = 1;
    tick();
    $display("C up wrap -> count=%0d wrap=%0b dir=%0b", c_count, c_wrap, c_dir);
    check("c_upwrap_count", int'(c_count), 1);
    check("c_upwrap_wrap", int'(c_wrap), 1);
    c_en = 0;
    tick();
    check("c_wrap_pulse_end", int'(c_wrap), 0);
    c_en = 1; c_dir_in = 0;
    tick();
    $display("C down wrap -> count=%0d wrap=%0b dir=%0b", c_count, c_wrap, c_dir);
    check("c_dnwrap_count", int'(c_count), 7);
    check("c_dnwrap_wrap", int'(c_wrap), 1);
    check("c_dnwrap_dir", int'(c_dir), 0);
    tick();
    c_en = 0;
    check("c_step_count", int'(c_count), 5);
    check("c_step_wrap", int'(c_wrap), 0);
    check("c_turn_tied", int'(c_turn), 0);

    // D: even bounce 0,2,4,6,4,2,0
    begin
      int exp_d[7] = '{2, 4, 6, 4, 2, 0, 2};
      int exp_t[7] = '{0, 0, 1, 0, 0, 1, 0};
      d_en = 1;
      for (int i = 0; i < 7; i++) begin
        tick();
        $display("D step %0d -> count=%0d turn=%0b", i, d_count, d_turn);
        check($sformatf("d_step%0d_count", i), int'(d_count), exp_d[i]);
        check($sformatf("d_step%0d_turn", i), int'(d_turn), exp_t[i]);
        check($sformatf("d_step%0d_lsb", i), int'(d_count[0]), 0);
      end
      d_en = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/odd_bounce_counter.md
Name: odd_bounce_counter

Overview:
- Parametrised successor to the fixed 3-bit odd up/down counter used in the DFT test vehicle.
- Steps by 2 through all odd values (or all even values) of a WIDTH-bit range. Either bounces between the endpoints or wraps, with synchronous load, enable and endpoint-event pulses.
- Sits in the DFT block set as a known-sequence pattern source; an optional scan chain makes its state controllable and observable.

Parameters:
- WIDTH, 3: counter width in bits; legal values are 2 to 16.
- PARITY, 1: 1 = odd sequence (MIN=1, MAX=2^WIDTH-1); 0 = even sequence (MIN=0, MAX=2^WIDTH-2).
- MODE, 0: 0 = bounce (reverses at the endpoints); 1 = wrap (direction taken from dir_in).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: advance one step per clock while high.
- load, input, 1: synchronous load of load_val; takes priority over en.
- load_val, input, WIDTH: load value; bit 0 is forced to PARITY on capture.
- dir_in, input, 1: wrap-mode direction, 1 = up. Ignored when MODE=0.
- count, output, WIDTH: current count, registered.
- dir, output, 1: current direction, 1 = up, registered.
- turn, output, 1: one-cycle pulse, registered.
- wrap, output, 1: one-cycle pulse, registered.

Behaviour:
- Reset (async assert, sync-safe deassert): count=MIN, dir=1, turn=0, wrap=0.
- All outputs are registered. A step is visible on count one clock after the qualifying edge.
- Priority order: rst_n, then load, then en, then hold.
- Load:
  - count <= {load_val[WIDTH-1:1], PARITY}.
  - dir <= 0 if the captured value equals MAX; dir <= 1 if it equals MIN; otherwise dir is unchanged (MODE=0).
  - In MODE=1, dir <= dir_in.
  - turn=0 and wrap=0 on a load cycle.
- Hold (en=0, load=0): count and dir are unchanged; turn=0, wrap=0.
- Bounce step (MODE=0, en=1):
  - dir=1 and count<MAX: count+=2.
  - dir=0 and count>MIN: count-=2.
  - On the step that makes count==MAX, dir <= 0 on the same edge and turn=1 for that one cycle. The same applies at MIN, with dir <= 1.
  - Defensive case (cannot occur after legal operation): count already at the endpoint in the travel direction. The counter reverses immediately and steps away; turn is not asserted.
  - Example, WIDTH=3, PARITY=1: 1,3,5,7,5,3,1,3,...
- Wrap step (MODE=1, en=1):
  - dir <= dir_in every enabled cycle; the step direction is the sampled dir_in.
  - Up from MAX gives MIN; down from MIN gives MAX; wrap=1 for the one cycle following the wrap edge.
  - turn is tied to 0.
- Arithmetic: modulo 2^WIDTH internally, with one guard bit; no value of the wrong parity is ever produced.
- en toggled mid-sequence: no state loss and no spurious pulse.
- rst_n asserted mid-step: outputs go to reset values immediately, without waiting for a clock.
- Simultaneous load and en: load wins and no step occurs.

Optional Feature:
- Macro: ODD_BOUNCE_COUNTER_SCAN_EN.
- When defined, three ports are added:
  - scan_en, input, 1.
  - scan_in, input, 1.
  - scan_out, output, 1.
- Scan chain contents:
  - The chain covers {dir, count[WIDTH-1:0], turn, wrap}, WIDTH+3 flops in total.
  - Shift order is scan_in into dir first, then count MSB to LSB, turn, wrap.
  - scan_out is the wrap flop.
- scan_en=1 behaviour:
  - The chain shifts on every clk and overrides load/en.
  - Parity forcing is bypassed, so any pattern can be shifted in.
  - rst_n still dominates.
- When undefined, the ports and the mux logic are absent and function is identical.

Decomposition:
- Package odd_counter_pkg holds:
  - MODE_BOUNCE / MODE_WRAP localparams.
  - Functions cnt_min(WIDTH,PARITY) and cnt_max(WIDTH,PARITY).
  - SCAN_LEN = WIDTH+3.
- One sub-module, scan_dff: async-reset-low D flop with a scan mux. It is instantiated per state bit when the macro is defined and is a plain flop otherwise.

Test Plan:
- Reset then en=1 for 8 clocks (WIDTH=3, PARITY=1, MODE=0) -> count 3,5,7,5,3,1,3,5; turn high exactly on the cycles count=7 and count=1; dir flips on those edges.
- load=1 with load_val=4'b0110, en=1 (WIDTH=4, PARITY=1) -> count=7, dir unchanged, no turn. load_val=15 -> count=15, dir=0; next step gives 13.
- MODE=1, WIDTH=3, count=7, dir_in=1, en=1 -> count=1, wrap=1 for one cycle. Then dir_in=0 at count=1 -> count=7, wrap=1.
- PARITY=0, WIDTH=3 bounce -> 0,2,4,6,4,2,0; no odd value ever appears.
- rst_n pulled low between clock edges at count=5 -> count=1, dir=1 immediately. en=0 for 3 cycles -> count is held and no pulses occur.
- With ODD_BOUNCE_COUNTER_SCAN_EN defined, scan_en=1 and 6 shifts of 1,0,1,1,0,0 (WIDTH=3) -> dir=1, count=3'b011, turn=0, wrap=0. Then scan_en=0, en=1 -> count=5.
